// File: rtl/cic_sched_pkg.sv
// Shared definitions for the CIC interpolator rate scheduler:
// FSM state encoding and the width of the output statistics counter.
package cic_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_FLUSH = 2'd2;
  localparam state_t S_DRAIN = 2'd3;

  localparam int OUT_CNT_W = 16;

endpackage

// File: rtl/cic_sched_fifo.sv
// Small synchronous FIFO with combinational head read; push is dropped when full,
// pop is dropped when empty, so callers may gate loosely.
module cic_sched_fifo #(
  parameter int Win    = 16,
  parameter int FDEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  logic [Win-1:0] wdata_i,
  input  logic           pop_i,
  output logic [Win-1:0] rdata_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FDEPTH);

  logic [Win-1:0] mem_q [FDEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cic_interp_sched.sv
// Rate scheduler feeding a CIC interpolator: one registered sample + strobe every R clocks,
// zero-flush and drain on stop. Optional output counter enabled by CIC_SCHED_STATS_EN.
module cic_interp_sched
  import cic_sched_pkg::*;
#(
  parameter int Win       = 16,
  parameter int RW        = 8,
  parameter int FDEPTH    = 4,
  parameter int NFLUSH    = 3,
  parameter int DRAIN_CYC = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [RW-1:0]        cfg_rate_i,
  input  logic                 cfg_load_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [Win-1:0]       s_data_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  output logic [Win-1:0]       cic_data_o,
  output logic                 cic_val_o,
  input  logic                 cic_val_out_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 underrun_o,
  output logic                 cfg_err_o,
  output logic [OUT_CNT_W-1:0] out_cnt_o
);

  localparam int FW = $clog2(NFLUSH + 1);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(NFLUSH - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  state_t          state_q, state_d;
  logic [RW-1:0]   rate_q, rate_d;
  logic [RW-1:0]   tick_q, tick_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [Win-1:0]  cic_data_q, cic_data_d;
  logic            cic_val_q, underrun_q, underrun_d;
  logic            done_q, cfg_err_q, rdy_en_q;

  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [Win-1:0]  fifo_head;

  logic            active, strobe, start_go, flush_last, drain_last;
  logic            underrun_set, zero_issue;
  logic [Win-1:0]  issue_data;

  cic_sched_fifo #(
    .Win    (Win),
    .FDEPTH (FDEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (s_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign active     = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign strobe     = active && (tick_q == rate_q - 1'b1);
  assign start_go   = (state_q == S_IDLE) && start_i;
  // Leave FLUSH on the strobe that issues the final zero, so DRAIN starts as it becomes visible.
  assign flush_last = (state_q == S_FLUSH) && strobe && fifo_empty && (flush_cnt_q == FLUSH_LAST);
  assign drain_last = (state_q == S_DRAIN) && (drain_cnt_q == DRAIN_LAST);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i)    state_d = S_RUN;
      S_RUN:   if (stop_i)     state_d = S_FLUSH;
      S_FLUSH: if (flush_last) state_d = S_DRAIN;
      S_DRAIN: if (drain_last) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // FSM: outputs and strobe-side controls
  always_comb begin
    fifo_pop     = strobe && !fifo_empty;
    issue_data   = fifo_empty ? '0 : fifo_head;
    underrun_set = strobe && fifo_empty && (state_q == S_RUN);
    zero_issue   = strobe && fifo_empty && (state_q == S_FLUSH);
    // rdy_en_q keeps s_ready low while in and just after reset.
    s_ready_o    = rdy_en_q && !fifo_full && ((state_q == S_IDLE) || (state_q == S_RUN));
    busy_o       = (state_q != S_IDLE);
    fifo_push    = s_valid_i && s_ready_o;
  end

  always_comb begin
    rate_d      = rate_q;
    tick_d      = tick_q;
    flush_cnt_d = flush_cnt_q;
    drain_cnt_d = drain_cnt_q;
    cic_data_d  = cic_data_q;
    underrun_d  = underrun_q;

    if (cfg_load_i && (state_q == S_IDLE))
      rate_d = (cfg_rate_i == '0) ? RW'(1) : cfg_rate_i;

    if (start_go)    tick_d = '0;
    else if (active) tick_d = strobe ? '0 : tick_q + 1'b1;

    if (state_q != S_FLUSH) flush_cnt_d = '0;
    else if (zero_issue)    flush_cnt_d = flush_cnt_q + 1'b1;

    if (state_q != S_DRAIN) drain_cnt_d = '0;
    else                    drain_cnt_d = drain_cnt_q + 1'b1;

    if (strobe) cic_data_d = issue_data;

    if (start_go)          underrun_d = 1'b0;
    else if (underrun_set) underrun_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rate_q      <= RW'(1);
      tick_q      <= '0;
      flush_cnt_q <= '0;
      drain_cnt_q <= '0;
      cic_data_q  <= '0;
      cic_val_q   <= 1'b0;
      underrun_q  <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      rate_q      <= rate_d;
      tick_q      <= tick_d;
      flush_cnt_q <= flush_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      cic_data_q  <= cic_data_d;
      cic_val_q   <= strobe;
      underrun_q  <= underrun_d;
      done_q      <= drain_last;
      cfg_err_q   <= cfg_load_i && (state_q != S_IDLE);
      rdy_en_q    <= 1'b1;
    end
  end

  assign cic_data_o = cic_data_q;
  assign cic_val_o  = cic_val_q;
  assign underrun_o = underrun_q;
  assign done_o     = done_q;
  assign cfg_err_o  = cfg_err_q;

`ifdef CIC_SCHED_STATS_EN
  logic [OUT_CNT_W-1:0] out_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                             out_cnt_q <= '0;
    else if (start_go)                       out_cnt_q <= '0;
    else if (cic_val_out_i && out_cnt_q != '1) out_cnt_q <= out_cnt_q + 1'b1;
  end

  assign out_cnt_o = out_cnt_q;
`else
  logic unused_val_out;
  assign unused_val_out = cic_val_out_i;
  assign out_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_cic_interp_sched.sv
// Directed scoreboard bench for cic_interp_sched: accepted samples and expected zeros
// are queued and compared against every cic_val strobe.
module tb_cic_interp_sched;

  localparam int WIN = 16;
  localparam int RW  = 8;

  logic            clk = 1'b0;
  logic            rst_n, cfg_load, start, stop, s_valid, cic_val_out;
  logic [RW-1:0]   cfg_rate;
  logic [WIN-1:0]  s_data;
  logic            s_ready, cic_val, busy, done, underrun, cfg_err;
  logic [WIN-1:0]  cic_data;
  logic [15:0]     out_cnt;

  int              n_tests = 0;
  int              n_fail  = 0;
  int              n_val   = 0;
  bit              zero_ok = 1'b0;
  logic [WIN-1:0]  exp_q[$];

  always #5 clk = ~clk;

  cic_interp_sched dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cfg_rate_i    (cfg_rate),
    .cfg_load_i    (cfg_load),
    .start_i       (start),
    .stop_i        (stop),
    .s_data_i      (s_data),
    .s_valid_i     (s_valid),
    .s_ready_o     (s_ready),
    .cic_data_o    (cic_data),
    .cic_val_o     (cic_val),
    .cic_val_out_i (cic_val_out),
    .busy_o        (busy),
    .done_o        (done),
    .underrun_o    (underrun),
    .cfg_err_o     (cfg_err),
    .out_cnt_o     (out_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each strobe first, then record a sample that will be accepted at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cic_val) begin
        n_val++;
        $display("[TB] strobe %0d data %0h", n_val, cic_data);
        if (exp_q.size() > 0)  check("cic_data", cic_data, exp_q.pop_front());
        else if (zero_ok)      check("cic_data_zero", cic_data, 0);
        else begin
          n_tests++;
          n_fail++;
          $error("FAIL unexpected_strobe: observed cic_val=1 data %0h expected no strobe", cic_data);
        end
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [WIN-1:0] d);
    int guard = 0;
    s_data  = d;
    s_valid = 1'b1;
    do begin @(negedge clk); guard++; end while (!s_ready && guard < 100);
    if (!s_ready) begin n_tests++; n_fail++; $error("FAIL send_timeout: observed s_ready=0 expected 1"); end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_val(output int cyc_cnt);
    cyc_cnt = 0;
    do begin @(negedge clk); cyc_cnt++; end while (!cic_val && cyc_cnt < 200);
    if (!cic_val) begin n_tests++; n_fail++; $error("FAIL val_timeout: observed no cic_val expected strobe"); end
  endtask

  task automatic wait_done(output int cnt, output int last);
    cnt  = 0;
    last = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cic_val) last = cnt;
    end while (!done && cnt < 400);
    check("done_seen", done, 1);
  endtask

  initial begin
    int c, cnt, last, n0;
    rst_n = 1'b0; cfg_load = 1'b0; cfg_rate = '0; start = 1'b0; stop = 1'b0;
    s_valid = 1'b0; s_data = '0; cic_val_out = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_cic_val", cic_val, 0);
    check("rst_cic_data", cic_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_out_cnt", out_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(1);
    @(negedge clk);
    check("idle_s_ready", s_ready, 1);

    // 1: R=4, prefill 1..4, start
    cyc(1);
    cfg_rate = 8'd4; cfg_load = 1'b1;
    cyc(1);
    cfg_load = 1'b0;
    @(negedge clk);
    check("cfg_err_idle_load", cfg_err, 0);
    cyc(1);
    for (int i = 1; i <= 4; i++) send(WIN'(i));
    s_data = 16'd5; s_valid = 1'b1;
    @(negedge clk);
    check("full_s_ready", s_ready, 0);
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_val(c);
    check("first_latency", c, 5);
    check("s_ready_after_pop", s_ready, 1);
    @(posedge clk); #1 s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_val(c);
      check("gap_r4", c, 4);
    end

    // 2: FIFO now empty -> underrun strobe carries zero
    check("underrun_before", underrun, 0);
    zero_ok = 1'b1;
    wait_val(c);
    check("gap_underrun", c, 4);
    check("underrun_set", underrun, 1);

    // 3: stop with two samples queued -> 2 data + 3 zero strobes, 16-cycle drain
    @(posedge clk); #1;
    zero_ok = 1'b0;
    s_data = 16'd6; s_valid = 1'b1;
    @(posedge clk); #1;
    s_data = 16'd7; stop = 1'b1;
    n0 = n_val;
    @(posedge clk); #1;
    s_valid = 1'b0; stop = 1'b0;
    for (int z = 0; z < 3; z++) exp_q.push_back('0);
    @(negedge clk);
    check("flush_s_ready", s_ready, 0);
    check("flush_busy", busy, 1);
    wait_done(cnt, last);
    check("flush_strobes", n_val - n0, 5);
    check("drain_cycles", cnt - last, 16);
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("busy_after_done", busy, 0);
    check("underrun_sticky", underrun, 1);
    check("queue_empty_t3", exp_q.size(), 0);

    // 4: R=0 -> every cycle; load during RUN -> cfg_err, rate kept
    cyc(1);
    cfg_rate = 8'd0; cfg_load = 1'b1;
    cyc(1);
    cfg_load = 1'b0; start = 1'b1; zero_ok = 1'b1;
    cyc(1);
    start = 1'b0;
    @(negedge clk);
    check("underrun_cleared", underrun, 0);
    wait_val(c);
    check("first_latency_r1", c + 1, 2);
    for (int k = 0; k < 3; k++) begin
      wait_val(c);
      check("gap_r1", c, 1);
    end
    @(posedge clk); #1;
    cfg_rate = 8'd7; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", cfg_err, 1);
    @(negedge clk);
    check("cfg_err_clear", cfg_err, 0);
    wait_val(c);
    check("gap_r1_after_load", c, 1);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_done(cnt, last);
    zero_ok = 1'b0;

    // 6: reset mid-FLUSH, then stats counter
    cyc(1);
    cfg_rate = 8'd4; cfg_load = 1'b1;
    cyc(1);
    cfg_load = 1'b0;
    send(16'h00A0);
    send(16'h00A1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_val(c);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    for (int z = 0; z < 3; z++) exp_q.push_back('0);
    wait_val(c);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_cic_val", cic_val, 0);
    check("mid_rst_cic_data", cic_data, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_done", done, 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(1);
    @(negedge clk);
    check("post_rst_idle", busy, 0);
    check("post_rst_no_val", cic_val, 0);
    @(posedge clk); #1;
    start = 1'b1; zero_ok = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int p = 0; p < 10; p++) begin
      cic_val_out = 1'b1;
      cyc(1);
      cic_val_out = 1'b0;
      cyc(1);
    end
    @(negedge clk);
`ifdef CIC_SCHED_STATS_EN
    check("out_cnt", out_cnt, 10);
`else
    check("out_cnt", out_cnt, 0);
`endif
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_done(cnt, last);
    @(negedge clk);
    check("final_idle", busy, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
